// File: rtl/vx_rop_req_arb.sv
// vx_rop_req_arb: round-robin arbiter sharing one ROP request port among
// NUM_REQS requesters. The winning bundle and its source index are pushed into
// a 2-entry output buffer. The ROP side therefore sees a registered valid and
// registered data. The requester side sees a ready gated by a registered
// "space" flag, so req_ready never depends combinationally on rop_ready.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_uuid/req_mask/req_pos_x/req_pos_y/req_color/req_depth/
//   req_face : per-requester request bundles (packed, requester 0 in the LSBs)
//   req_ready  : one-hot (or zero) grant back to the requesters
//   rop_valid/rop_* : buffered bundle towards the ROP unit
//   rop_idx    : requester that produced the current bundle
//   rop_ready  : ROP accepts the head bundle
//
// Optional build macro VX_ROP_ARB_PERF_EN adds the following counters:
//   perf_grants : per-requester count of enqueued bundles, 44 bits each
//   perf_stalls : count of cycles where rop_valid=1 and rop_ready=0
// The arbitration logic is identical with or without the macro.

`ifndef UP
`define UP(x) (((x) > 0) ? (x) : 1)
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef ROP_DIM_BITS
`define ROP_DIM_BITS 11
`endif
`ifndef ROP_DEPTH_BITS
`define ROP_DEPTH_BITS 24
`endif

module vx_rop_req_arb #(
    parameter int NUM_REQS  = 4,
    parameter int NUM_LANES = 4,
    parameter int UUIDW     = `UP(`UUID_BITS),
    localparam int IDXW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int DW       = `ROP_DIM_BITS,
    localparam int ZW       = `ROP_DEPTH_BITS
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQS-1:0]             req_valid,
    input  logic [NUM_REQS*UUIDW-1:0]       req_uuid,
    input  logic [NUM_REQS*NUM_LANES-1:0]   req_mask,
    input  logic [NUM_REQS*NUM_LANES*DW-1:0] req_pos_x,
    input  logic [NUM_REQS*NUM_LANES*DW-1:0] req_pos_y,
    input  logic [NUM_REQS*NUM_LANES*32-1:0] req_color,
    input  logic [NUM_REQS*NUM_LANES*ZW-1:0] req_depth,
    input  logic [NUM_REQS*NUM_LANES-1:0]   req_face,
    output logic [NUM_REQS-1:0]             req_ready,
    output logic                            rop_valid,
    output logic [UUIDW-1:0]                rop_uuid,
    output logic [NUM_LANES-1:0]            rop_mask,
    output logic [NUM_LANES*DW-1:0]         rop_pos_x,
    output logic [NUM_LANES*DW-1:0]         rop_pos_y,
    output logic [NUM_LANES*32-1:0]         rop_color,
    output logic [NUM_LANES*ZW-1:0]         rop_depth,
    output logic [NUM_LANES-1:0]            rop_face,
    output logic [IDXW-1:0]                 rop_idx,
    input  logic                            rop_ready
`ifdef VX_ROP_ARB_PERF_EN
    ,
    output logic [NUM_REQS*44-1:0]          perf_grants,
    output logic [43:0]                     perf_stalls
`endif
);

    localparam int unsigned NR = NUM_REQS;

    typedef struct packed {
        logic [IDXW-1:0]         idx;
        logic [UUIDW-1:0]        uuid;
        logic [NUM_LANES-1:0]    mask;
        logic [NUM_LANES*DW-1:0] pos_x;
        logic [NUM_LANES*DW-1:0] pos_y;
        logic [NUM_LANES*32-1:0] color;
        logic [NUM_LANES*ZW-1:0] depth;
        logic [NUM_LANES-1:0]    face;
    } bundle_t;

    logic [1:0]      r_count;
    logic            r_space;
    logic [IDXW-1:0] r_ptr;
    bundle_t         r_head;
    bundle_t         r_tail;

    logic            w_found;
    logic [IDXW-1:0] w_grant_idx;
    logic [IDXW-1:0] w_cand;
    logic [IDXW-1:0] w_ptr_nxt;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_count_nxt;
    bundle_t         w_bundle;

    // Scan pointer, pointer+1, ... with a single conditional wrap.
    // pointer+k never reaches 2*NR, so one subtraction replaces the modulo.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            w_cand = (32'(r_ptr) + k >= NR) ? IDXW'(32'(r_ptr) + k - NR)
                                            : IDXW'(32'(r_ptr) + k);
            if (r_space && !w_found && req_valid[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign req_ready = w_found ? (NUM_REQS'(1) << w_grant_idx) : '0;
    assign w_ptr_nxt = (w_grant_idx == IDXW'(NR - 1)) ? '0 : w_grant_idx + 1'b1;

    assign w_bundle.idx   = w_grant_idx;
    assign w_bundle.uuid  = req_uuid[w_grant_idx*UUIDW +: UUIDW];
    assign w_bundle.mask  = req_mask[w_grant_idx*NUM_LANES +: NUM_LANES];
    assign w_bundle.pos_x = req_pos_x[w_grant_idx*NUM_LANES*DW +: NUM_LANES*DW];
    assign w_bundle.pos_y = req_pos_y[w_grant_idx*NUM_LANES*DW +: NUM_LANES*DW];
    assign w_bundle.color = req_color[w_grant_idx*NUM_LANES*32 +: NUM_LANES*32];
    assign w_bundle.depth = req_depth[w_grant_idx*NUM_LANES*ZW +: NUM_LANES*ZW];
    assign w_bundle.face  = req_face[w_grant_idx*NUM_LANES +: NUM_LANES];

    // Zero-mask requests are accepted and consumed, but are never buffered.
    assign w_push = w_found && (|w_bundle.mask);
    assign w_pop  = (r_count != 2'd0) && rop_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_space <= 1'b0;
            r_ptr   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= w_count_nxt;
            // Computed from the next count so that a full buffer blocks grants in the same cycle it fills.
            r_space <= (w_count_nxt != 2'd2);
            if (w_found) begin
                r_ptr <= w_ptr_nxt;
            end
            // The head is always rop_*; when the buffer holds one entry that is
            // also popped, the new entry goes directly into the head.
            if (w_push) begin
                if (r_count == 2'd0 || (r_count == 2'd1 && w_pop)) begin
                    r_head <= w_bundle;
                end else begin
                    r_tail <= w_bundle;
                end
            end else if (w_pop && r_count == 2'd2) begin
                r_head <= r_tail;
            end
        end
    end

    assign rop_valid = (r_count != 2'd0);
    assign rop_idx   = r_head.idx;
    assign rop_uuid  = r_head.uuid;
    assign rop_mask  = r_head.mask;
    assign rop_pos_x = r_head.pos_x;
    assign rop_pos_y = r_head.pos_y;
    assign rop_color = r_head.color;
    assign rop_depth = r_head.depth;
    assign rop_face  = r_head.face;

`ifdef VX_ROP_ARB_PERF_EN
    logic [NUM_REQS*44-1:0] r_perf_grants;
    logic [43:0]            r_perf_stalls;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_grants <= '0;
            r_perf_stalls <= '0;
        end else begin
            for (int unsigned i = 0; i < NR; i++) begin
                if (w_push && w_grant_idx == IDXW'(i)) begin
                    r_perf_grants[i*44 +: 44] <= r_perf_grants[i*44 +: 44] + 44'd1;
                end
            end
            if (rop_valid && !rop_ready) begin
                r_perf_stalls <= r_perf_stalls + 44'd1;
            end
        end
    end

    assign perf_grants = r_perf_grants;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_vx_rop_req_arb.sv
// Testbench for vx_rop_req_arb (NUM_REQS=4, NUM_LANES=4).
// Table rows drive one cycle each from reset release onward; a few scripted
// sequences cover reset in mid-operation and, with VX_ROP_ARB_PERF_EN, the counters.
// Requester r in row n presents uuid n*16+r; the other fields are derived from the uuid.

`ifndef UP
`define UP(x) (((x) > 0) ? (x) : 1)
`endif
`ifndef UUID_BITS
`define UUID_BITS 44
`endif
`ifndef ROP_DIM_BITS
`define ROP_DIM_BITS 11
`endif
`ifndef ROP_DEPTH_BITS
`define ROP_DEPTH_BITS 24
`endif

module tb_vx_rop_req_arb;

    localparam int NR = 4;
    localparam int NL = 4;
    localparam int UW = `UP(`UUID_BITS);
    localparam int DW = `ROP_DIM_BITS;
    localparam int ZW = `ROP_DEPTH_BITS;

    logic                  clk;
    logic                  reset;
    logic [NR-1:0]         req_valid;
    logic [NR*UW-1:0]      req_uuid;
    logic [NR*NL-1:0]      req_mask;
    logic [NR*NL*DW-1:0]   req_pos_x;
    logic [NR*NL*DW-1:0]   req_pos_y;
    logic [NR*NL*32-1:0]   req_color;
    logic [NR*NL*ZW-1:0]   req_depth;
    logic [NR*NL-1:0]      req_face;
    logic [NR-1:0]         req_ready;
    logic                  rop_valid;
    logic [UW-1:0]         rop_uuid;
    logic [NL-1:0]         rop_mask;
    logic [NL*DW-1:0]      rop_pos_x;
    logic [NL*DW-1:0]      rop_pos_y;
    logic [NL*32-1:0]      rop_color;
    logic [NL*ZW-1:0]      rop_depth;
    logic [NL-1:0]         rop_face;
    logic [1:0]            rop_idx;
    logic                  rop_ready;
`ifdef VX_ROP_ARB_PERF_EN
    logic [NR*44-1:0]      perf_grants;
    logic [43:0]           perf_stalls;
`endif

    vx_rop_req_arb #(.NUM_REQS(NR), .NUM_LANES(NL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_uuid(req_uuid), .req_mask(req_mask),
        .req_pos_x(req_pos_x), .req_pos_y(req_pos_y), .req_color(req_color),
        .req_depth(req_depth), .req_face(req_face), .req_ready(req_ready),
        .rop_valid(rop_valid), .rop_uuid(rop_uuid), .rop_mask(rop_mask),
        .rop_pos_x(rop_pos_x), .rop_pos_y(rop_pos_y), .rop_color(rop_color),
        .rop_depth(rop_depth), .rop_face(rop_face), .rop_idx(rop_idx),
        .rop_ready(rop_ready)
`ifdef VX_ROP_ARB_PERF_EN
        , .perf_grants(perf_grants), .perf_stalls(perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  m1;
        logic [3:0]  m3;
        logic        rdy;
        logic [3:0]  e_ready;
        logic        e_valid;
        logic [1:0]  e_idx;
        logic [15:0] e_uuid;
        logic [3:0]  e_mask;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    task automatic set_req(input int unsigned r, input logic [UW-1:0] u, input logic [NL-1:0] m);
        req_uuid[r*UW +: UW] = u;
        req_mask[r*NL +: NL] = m;
        for (int unsigned l = 0; l < NL; l++) begin
            req_pos_x[(r*NL+l)*DW +: DW] = DW'(u + UW'(l));
            req_pos_y[(r*NL+l)*DW +: DW] = DW'(u + UW'(3*l+7));
            req_color[(r*NL+l)*32 +: 32] = 32'(u*5) ^ (32'(l) << 24);
            req_depth[(r*NL+l)*ZW +: ZW] = ZW'(u) + ZW'(l*100);
            req_face[r*NL+l]             = ~u[l];
        end
    endtask

    task automatic drive(input int n, input logic [3:0] v, input logic rdy,
                         input logic [3:0] m1, input logic [3:0] m3);
        req_valid = v;
        rop_ready = rdy;
        for (int unsigned r = 0; r < NR; r++) begin
            set_req(r, UW'(n*16 + int'(r)), (r == 1) ? m1 : ((r == 3) ? m3 : 4'hF));
        end
    endtask

    // Compare the non-key fields against the values derived from the uuid.
    task automatic chk_data(input string nm, input logic [UW-1:0] u);
        logic [NL*DW-1:0] ex, ey;
        logic [NL*32-1:0] ec;
        logic [NL*ZW-1:0] ed;
        logic [NL-1:0]    ef;
        for (int unsigned l = 0; l < NL; l++) begin
            ex[l*DW +: DW] = DW'(u + UW'(l));
            ey[l*DW +: DW] = DW'(u + UW'(3*l+7));
            ec[l*32 +: 32] = 32'(u*5) ^ (32'(l) << 24);
            ed[l*ZW +: ZW] = ZW'(u) + ZW'(l*100);
            ef[l]          = ~u[l];
        end
        checks++;
        if ({rop_pos_x, rop_pos_y, rop_color, rop_depth, rop_face} !== {ex, ey, ec, ed, ef}) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm,
                     {rop_pos_x, rop_pos_y, rop_color, rop_depth, rop_face}, {ex, ey, ec, ed, ef});
        end
    endtask

    initial begin
        //          valid  m1     m3     rdy   e_ready e_vld e_idx e_uuid    e_mask
        tbl[0]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'h000, 4'hF};
        tbl[1]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 2'd0, 16'h000, 4'hF};
        tbl[2]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'h2, 1'b1, 2'd0, 16'h010, 4'hF};
        tbl[3]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd1, 16'h021, 4'hF};
        tbl[4]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 2'd2, 16'h032, 4'hF};
        tbl[5]  = '{4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd3, 16'h043, 4'hF};
        tbl[6]  = '{4'h0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 16'h050, 4'hF};
        tbl[7]  = '{4'h0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'h000, 4'hF};
        tbl[8]  = '{4'h4, 4'hF, 4'hF, 1'b1, 4'h4, 1'b0, 2'd0, 16'h000, 4'hF};
        tbl[9]  = '{4'h4, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 16'h082, 4'hF};
        tbl[10] = '{4'h4, 4'hF, 4'hF, 1'b1, 4'h4, 1'b1, 2'd2, 16'h092, 4'hF};
        tbl[11] = '{4'h0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 16'h0A2, 4'hF};
        tbl[12] = '{4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 1'b0, 2'd0, 16'h000, 4'hF};
        tbl[13] = '{4'h0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd3, 16'h0C3, 4'hF};
        tbl[14] = '{4'h0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'h000, 4'hF};
        tbl[15] = '{4'h3, 4'hF, 4'hF, 1'b0, 4'h1, 1'b0, 2'd0, 16'h000, 4'hF};
        tbl[16] = '{4'h3, 4'hF, 4'hF, 1'b0, 4'h2, 1'b1, 2'd0, 16'h0F0, 4'hF};
        tbl[17] = '{4'h3, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'h0F0, 4'hF};
        tbl[18] = '{4'h3, 4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 2'd0, 16'h0F0, 4'hF};
        tbl[19] = '{4'h3, 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 16'h0F0, 4'hF};
        tbl[20] = '{4'h3, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 2'd1, 16'h101, 4'hF};
        tbl[21] = '{4'h0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd0, 16'h140, 4'hF};
        tbl[22] = '{4'h0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'h000, 4'hF};
        tbl[23] = '{4'hA, 4'h0, 4'h5, 1'b1, 4'h2, 1'b0, 2'd0, 16'h000, 4'hF};
        tbl[24] = '{4'hA, 4'h0, 4'h5, 1'b1, 4'h8, 1'b0, 2'd0, 16'h000, 4'hF};
        tbl[25] = '{4'h0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 2'd3, 16'h183, 4'h5};
        tbl[26] = '{4'h0, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 16'h000, 4'hF};

        reset     = 1'b0;
        rop_ready = 1'b0;
        req_valid = '0;
        req_uuid  = '0; req_mask  = '0; req_pos_x = '0; req_pos_y = '0;
        req_color = '0; req_depth = '0; req_face  = '0;

        repeat (2) @(posedge clk);
        #1 req_valid = 4'hF;
        @(negedge clk);
        chk("reset rop_valid", 64'(rop_valid), 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset rop_idx",   64'(rop_idx),   64'd0);
        chk("reset rop_uuid",  64'(rop_uuid),  64'd0);
        chk("reset rop_mask",  64'(rop_mask),  64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int n = 0; n < 27; n++) begin
            drive(n, tbl[n].valid, tbl[n].rdy, tbl[n].m1, tbl[n].m3);
            @(negedge clk);
            chk($sformatf("row%0d req_ready", n), 64'(req_ready), 64'(tbl[n].e_ready));
            chk($sformatf("row%0d rop_valid", n), 64'(rop_valid), 64'(tbl[n].e_valid));
            if (tbl[n].e_valid) begin
                chk($sformatf("row%0d rop_idx", n),  64'(rop_idx),  64'(tbl[n].e_idx));
                chk($sformatf("row%0d rop_uuid", n), 64'(rop_uuid), 64'(tbl[n].e_uuid));
                chk($sformatf("row%0d rop_mask", n), 64'(rop_mask), 64'(tbl[n].e_mask));
                chk_data($sformatf("row%0d data", n), UW'(tbl[n].e_uuid));
            end
            @(posedge clk);
            #1;
        end

        // Fill both entries (pointer moves to 2), then reset mid-cycle.
        drive(27, 4'b0011, 1'b0, 4'hF, 4'hF);
        @(negedge clk);
        chk("fill grant0", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        drive(28, 4'b0011, 1'b0, 4'hF, 4'hF);
        @(negedge clk);
        chk("fill grant1", 64'(req_ready), 64'h2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full rop_valid", 64'(rop_valid), 64'd1);
        chk("full req_ready", 64'(req_ready), 64'd0);
        chk("full rop_uuid",  64'(rop_uuid),  64'h1B0);
        #1 reset = 1'b0;
        #1;
        chk("midrst rop_valid", 64'(rop_valid), 64'd0);
        chk("midrst req_ready", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(29, 4'b0110, 1'b1, 4'hF, 4'hF);
        @(negedge clk);
        chk("post-rst space req_ready", 64'(req_ready), 64'd0);
        chk("post-rst rop_valid",       64'(rop_valid), 64'd0);
        @(posedge clk); #1;
        drive(30, 4'b0110, 1'b1, 4'hF, 4'hF);
        @(negedge clk);
        chk("post-rst first grant", 64'(req_ready), 64'h2);
        @(posedge clk); #1;
        drive(31, 4'b0000, 1'b1, 4'hF, 4'hF);
        @(negedge clk);
        chk("post-rst rop_valid", 64'(rop_valid), 64'd1);
        chk("post-rst rop_idx",   64'(rop_idx),   64'd1);
        chk("post-rst rop_uuid",  64'(rop_uuid),  64'h1E1);
        chk_data("post-rst data", UW'(12'h1E1));
        @(posedge clk); #1;

`ifdef VX_ROP_ARB_PERF_EN
        begin
            int g;
            int s;
            bit done;
            g = 0; s = 0; done = 1'b0;
            reset = 1'b0;
            req_valid = '0;
            #1 reset = 1'b1;
            @(posedge clk); #1;
            for (int c = 0; c < 200; c++) begin
                req_valid = (g < 10) ? 4'b0001 : 4'b0000;
                set_req(0, UW'(c + 1), 4'hF);
                rop_ready = 1'b1;
                if (rop_valid && s < 3 && c >= 4) begin
                    rop_ready = 1'b0;
                    s++;
                end
                @(negedge clk);
                if (req_ready[0]) g++;
                @(posedge clk); #1;
                if (g == 10 && s == 3 && !rop_valid) begin
                    done = 1'b1;
                    break;
                end
            end
            chk("perf drain within bound", 64'(done), 64'd1);
            chk("perf_grants[0]", 64'(perf_grants[43:0]), 64'd10);
            chk("perf_grants[1]", 64'(perf_grants[87:44]), 64'd0);
            chk("perf_stalls",    64'(perf_stalls), 64'd3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
